// File: rtl/dual_count_scheduler.sv
// Round-robin grant sequencer for two counters sharing one adder.
// Mirrors both counts and flags when both reach their latched targets.
module dual_count_scheduler #(
    parameter int WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] target1_i,
    input  logic [WIDTH-1:0] target2_i,
    input  logic             req1_i,
    input  logic             req2_i,
    output logic             ena1_o,
    output logic             ena2_o,
    output logic [WIDTH-1:0] count1_o,
    output logic [WIDTH-1:0] count2_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             valid_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt1_q, cnt1_d;
    logic [WIDTH-1:0] cnt2_q, cnt2_d;
    logic [WIDTH-1:0] tgt1_q, tgt1_d;
    logic [WIDTH-1:0] tgt2_q, tgt2_d;
    logic             ptr_q, ptr_d;

    logic elig1, elig2, at_tgt;
    logic g1, g2;

    assign elig1  = req1_i & (cnt1_q != tgt1_q);
    assign elig2  = req2_i & (cnt2_q != tgt2_q);
    assign at_tgt = (cnt1_q == tgt1_q) && (cnt2_q == tgt2_q);

    always_comb begin
        state_d = state_q;
        cnt1_d  = cnt1_q;
        cnt2_d  = cnt2_q;
        tgt1_d  = tgt1_q;
        tgt2_d  = tgt2_q;
        ptr_d   = ptr_q;
        g1      = 1'b0;
        g2      = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    tgt1_d  = target1_i;
                    tgt2_d  = target2_i;
                    cnt1_d  = '0;
                    cnt2_d  = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (at_tgt) begin
                    state_d = S_DONE;
                end else begin
                    // ptr breaks ties only when both sides are eligible
                    g1 = elig1 & (~elig2 | ~ptr_q);
                    g2 = elig2 & (~elig1 | ptr_q);
                    if (g1) begin
                        cnt1_d = cnt1_q + 1'b1;
                        ptr_d  = 1'b1;
                    end
                    if (g2) begin
                        cnt2_d = cnt2_q + 1'b1;
                        ptr_d  = 1'b0;
                    end
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt1_q  <= '0;
            cnt2_q  <= '0;
            tgt1_q  <= '0;
            tgt2_q  <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt1_q  <= cnt1_d;
            cnt2_q  <= cnt2_d;
            tgt1_q  <= tgt1_d;
            tgt2_q  <= tgt2_d;
            ptr_q   <= ptr_d;
        end
    end

    assign ena1_o   = g1;
    assign ena2_o   = g2;
    assign count1_o = cnt1_q;
    assign count2_o = cnt2_q;
    assign valid_o  = (cnt1_q != '1) | (cnt2_q != '1);

endmodule

// File: tb/tb_dual_count_scheduler.sv
// Directed-vector bench for dual_count_scheduler.
// Inputs change 1 time unit after the rising edge; outputs checked there.
module tb_dual_count_scheduler;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst, start, abort, req1, req2;
    logic [W-1:0] target1, target2;
    logic         ena1, ena2, busy, done, valid;
    logic [W-1:0] count1, count2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dual_count_scheduler #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .abort_i   (abort),
        .target1_i (target1),
        .target2_i (target2),
        .req1_i    (req1),
        .req2_i    (req2),
        .ena1_o    (ena1),
        .ena2_o    (ena2),
        .count1_o  (count1),
        .count2_o  (count2),
        .busy_o    (busy),
        .done_o    (done),
        .valid_o   (valid)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ena_code();
        return {30'd0, ena2, ena1};
    endfunction

    initial begin
        int          grants;
        int          cyc;
        logic        prev_valid, prev_busy, last_grant_valid, both_seen;
        logic [31:0] prev_ena;
        int          exp2 [5] = '{1, 2, 1, 2, 1};

        rst = 1; start = 0; abort = 0; req1 = 0; req2 = 0;
        target1 = '0; target2 = '0;

        // 1: reset
        tick(); tick();
        rst = 0;
        #1;
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_ena",   ena_code(), 0);
        check("rst_cnt1",  count1, 0);
        check("rst_cnt2",  count2, 0);
        check("rst_valid", valid, 1);

        // 2: alternating grants
        target1 = 3; target2 = 2; req1 = 1; req2 = 1; start = 1;
        tick();
        start = 0;
        #1;
        check("t2_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_ena%0d", i), ena_code(), exp2[i]);
            tick();
        end
        check("t2_ena_end", ena_code(), 0);
        check("t2_busy_end", busy, 1);
        tick();
        check("t2_done", done, 1);
        check("t2_busy_d", busy, 0);
        check("t2_cnt1", count1, 3);
        check("t2_cnt2", count2, 2);
        tick();
        check("t2_done_once", done, 0);

        // 3: counter 1 alone, then counter 2
        target1 = 5; target2 = 5; req1 = 1; req2 = 0; start = 1;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t3_ena1_%0d", i), ena_code(), 1);
            tick();
        end
        check("t3_idle_hold", ena_code(), 0);
        check("t3_cnt1", count1, 5);
        tick();
        check("t3_still_run", busy, 1);
        req2 = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("t3_ena2_%0d", i), ena_code(), 2);
            tick();
        end
        check("t3_ena_end", ena_code(), 0);
        tick();
        check("t3_done", done, 1);
        check("t3_cnt2", count2, 5);
        tick();

        // 4: full-range targets
        target1 = 12'hfff; target2 = 12'hfff; start = 1;
        tick();
        start = 0;
        grants = 0; cyc = 0; both_seen = 0;
        prev_valid = 1; prev_ena = 0; last_grant_valid = 0;
        while (!done && cyc < 9000) begin
            prev_valid = valid;
            prev_ena   = ena_code();
            if (ena1 && ena2) both_seen = 1;
            if (ena1 || ena2) begin
                grants++;
                last_grant_valid = valid;
            end
            tick();
            cyc++;
        end
        check("t4_timeout", {31'd0, done}, 1);
        check("t4_grants", grants, 8190);
        check("t4_exclusive", {31'd0, both_seen}, 0);
        check("t4_valid_pre", {31'd0, last_grant_valid}, 1);
        check("t4_valid_fell", {31'd0, prev_valid}, 0);
        check("t4_noena_last", prev_ena, 0);
        check("t4_cnt1", count1, 12'hfff);
        tick();

        // 5: abort mid-run
        target1 = 10; target2 = 10; start = 1;
        tick();
        start = 0;
        grants = 0;
        for (int i = 0; i < 4; i++) begin
            if (ena1 || ena2) grants++;
            tick();
        end
        check("t5_grants", grants, 4);
        abort = 1;
        #1;
        check("t5_abort_ena", ena_code(), 0);
        tick();
        check("t5_busy", busy, 0);
        check("t5_ena", ena_code(), 0);
        check("t5_cnt1", count1, 2);
        check("t5_cnt2", count2, 2);
        tick();
        check("t5_abort_idle", busy, 0);
        abort = 0;
        start = 1;
        tick();
        start = 0;
        check("t5_clr1", count1, 0);
        check("t5_clr2", count2, 0);
        check("t5_busy2", busy, 1);

        // 6: reset mid-run, then zero targets
        tick(); tick();
        check("t6_pre_cnt", count1 + count2, 2);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_ena", ena_code(), 0);
        check("t6_cnt1", count1, 0);
        check("t6_cnt2", count2, 0);
        rst = 1; start = 1;
        tick();
        rst = 0; start = 0;
        check("t6_rst_over_start", busy, 0);
        target1 = 0; target2 = 0; start = 1;
        tick();
        start = 0;
        check("t6z_busy", busy, 1);
        check("t6z_ena", ena_code(), 0);
        tick();
        check("t6z_done", done, 1);
        start = 1;
        tick();
        start = 0;
        check("t6z_start_in_done", busy, 0);
        check("t6z_done_low", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
